demux_sched: RTL and testbench
==============================

# demux_sched

Sequencing controller for the Buffer1 → Demux → {ALU, Buffer2} path. It accepts tagged 32-bit words from Buffer1 through a valid/ready handshake and registers each word onto the demux `Q1` input. It drives the demux `op` select and presents a valid/ready handshake toward the selected sink. A stalled sink is aborted after a bounded wait and flagged with a sticky error.

## Interface
- `DATA_W`, 32, word width; matches demux `Q1`.
- `TIMEOUT`, 15, maximum SEND cycles without sink handshake before abort; legal range 1..255.
- `CNT_W`, 16, width of the statistics counters.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  Buffer1 word available.
- `in_data`  in  DATA_W  word from Buffer1.
- `in_op`  in  1  destination tag: 0 = ALU, 1 = Buffer2.
- `in_ready`  out  1  word accepted on `in_valid && in_ready`.
- `q1`  out  DATA_W  registered word to demux `Q1`.
- `op`  out  1  registered demux select.
- `alu_valid`  out  1  word on ALU leg valid.
- `alu_ready`  in  1  ALU consumes word.
- `buf2_valid`  out  1  word on Buffer2 leg valid.
- `buf2_ready`  in  1  Buffer2 consumes word.
- `busy`  out  1  high in SEND.
- `timeout_err`  out  1  sticky abort flag.
- `err_clr`  in  1  synchronous clear of `timeout_err`.
- `alu_count`, `buf2_count`  out  CNT_W each  delivered-word counters; present only with `DEMUX_SCHED_STATS_EN`.

## Operation
- States: IDLE, SEND.
- **IDLE**
  - `in_ready`=1, both sink valids 0, `q1`=0, `op`=0.
  - On `in_valid`: capture `in_data` into `q1` and `in_op` into `op`, clear the wait counter, go to SEND.
- **SEND**
  - `alu_valid` = !`op`; `buf2_valid` = `op`. Never both high.
  - `q1` and `op` stay stable until the handshake completes.
  - Sink handshake is `sel_ready` = (`op` ? `buf2_ready` : `alu_ready`).
  - `in_ready` = `sel_ready`.
    - Handshake with `in_valid`: load the new word and op, clear the wait counter, stay in SEND. Back-to-back delivery, including an op change.
    - Handshake without `in_valid`: clear `q1`/`op` to 0, go to IDLE.
  - The non-selected sink's ready is ignored.
- **Wait counter**
  - 8 bits; increments each SEND cycle without `sel_ready`.
  - On the cycle it would reach `TIMEOUT`:
    - word dropped, `q1`/`op` cleared, go to IDLE;
    - `timeout_err` set;
    - no counter increment.
  - `in_ready` is 0 on that abort cycle.
- `err_clr` clears `timeout_err`. A set in the same cycle wins.
- Counters increment on a completed handshake to their sink and saturate at all-ones.
- `busy` = (state == SEND).

## Timing
- Reset values:
  - state IDLE;
  - `q1` 0, `op` 0;
  - all valids 0;
  - `in_ready` 1 after reset release;
  - `busy` 0, `timeout_err` 0;
  - counters 0.
- Reset asserted mid-SEND: word lost, outputs go to reset values immediately (asynchronous).
- Latency: word accepted at edge N appears on `q1`/`op` with the sink valid from edge N onward (1 cycle after the `in_valid` cycle).
- Throughput: 1 word/cycle while the selected sink holds ready.
- Abort: a word with no sink ready is dropped at the end of its `TIMEOUT`-th SEND cycle. With `TIMEOUT`=15: valid for cycles 1..15, IDLE on cycle 16.
- `in_ready` is combinational from `alu_ready`/`buf2_ready`. There are no other combinational input→output paths.

## Configuration
- `DEMUX_SCHED_STATS_EN`
  - Defined: `alu_count`/`buf2_count` ports and saturating counters exist.
  - Undefined: ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package `jericalla_pkg`:
  - `typedef enum logic {DST_ALU=1'b0, DST_BUF2=1'b1} dst_e`, shared with the demux op encoding;
  - state enum `sched_state_e {S_IDLE, S_SEND}`.
- One sub-module, `sat_counter` (CNT_W, increment enable, saturate), instantiated twice under the macro.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=0x0000_00A5, `in_op`=0, `alu_ready`=1 → next cycle `q1`=0x0000_00A5, `op`=0, `alu_valid`=1, `buf2_valid`=0; following cycle IDLE with `q1`=0.
- Stream 0x11 (op 0), 0x22 (op 1), 0x33 (op 0) back-to-back, both sinks ready → three consecutive cycles of valid on ALU, Buffer2, ALU; `in_ready` stays 1; with stats, `alu_count`=2 and `buf2_count`=1.
- Word 0xDEAD_BEEF, op 1, `buf2_ready` held 0 for 3 cycles then 1 → `q1`/`op` stable for 4 cycles; `in_ready` 0 for the first 3; `alu_valid` never asserts; a toggling `alu_ready` has no effect.
- `TIMEOUT`=15, `alu_ready`=0 forever → `alu_valid` high for 15 cycles, then IDLE, `timeout_err`=1, `alu_count` unchanged. `err_clr` pulse → 0. `err_clr` in the same cycle as the abort → `timeout_err`=1.
- Assert `rst_n`=0 mid-SEND holding 0x1234_5678 → `q1`=0, `alu_valid`/`buf2_valid`=0, `busy`=0 before the next clock edge; counters 0.
- Stats build: 2^CNT_W+3 ALU deliveries → `alu_count` saturates at all-ones. Non-stats build: no counter ports are present, and the other tests pass unchanged.

Source files
------------

// File: rtl/jericalla_pkg.sv
// Shared types for the Buffer1 -> Demux -> {ALU, Buffer2} path: destination tag
// (identical to the demux op encoding) and scheduler state encoding.
package jericalla_pkg;

  typedef enum logic {
    DST_ALU  = 1'b0,
    DST_BUF2 = 1'b1
  } dst_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } sched_state_e;

  localparam int unsigned WAIT_W = 8;

  // Number of sink legs, indexed by dst_e.
  localparam int unsigned NUM_DST = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/demux_sched.sv
// Sequencing controller feeding the demux Q1/op inputs with a bounded-wait abort.
// Optional delivered-word statistics are built when DEMUX_SCHED_STATS_EN is defined.
module demux_sched
  import jericalla_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_op,
  output logic              in_ready,
  output logic [DATA_W-1:0] q1,
  output logic              op,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic              buf2_valid,
  input  logic              buf2_ready,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]  alu_count,
  output logic [CNT_W-1:0]  buf2_count
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  sched_state_e      state_reg, state_next;
  logic [DATA_W-1:0] q1_reg, q1_next;
  dst_e              op_reg, op_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              timeout_err_reg, timeout_err_next;

  logic              sel_ready;
  logic              abort;
  logic [NUM_DST-1:0] deliver;

  assign sel_ready = (op_reg == DST_BUF2) ? buf2_ready : alu_ready;

  always_comb begin
    state_next    = state_reg;
    q1_next       = q1_reg;
    op_next       = op_reg;
    wait_cnt_next = wait_cnt_reg;
    abort         = 1'b0;
    in_ready      = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          q1_next       = in_data;
          op_next       = dst_e'(in_op);
          wait_cnt_next = '0;
          state_next    = S_SEND;
        end
      end

      S_SEND: begin
        in_ready = sel_ready;
        if (sel_ready) begin
          wait_cnt_next = '0;
          if (in_valid) begin
            q1_next = in_data;
            op_next = dst_e'(in_op);
          end else begin
            q1_next    = '0;
            op_next    = DST_ALU;
            state_next = S_IDLE;
          end
        end else if (wait_cnt_reg + 1'b1 == WAIT_LIMIT) begin
          // Stalled sink: drop the word without bumping the counter.
          abort      = 1'b1;
          q1_next    = '0;
          op_next    = DST_ALU;
          state_next = S_IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Abort outranks a clear arriving in the same cycle.
  always_comb begin
    timeout_err_next = timeout_err_reg;
    if (abort) begin
      timeout_err_next = 1'b1;
    end else if (err_clr) begin
      timeout_err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      q1_reg          <= '0;
      op_reg          <= DST_ALU;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      q1_reg          <= q1_next;
      op_reg          <= op_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign q1          = q1_reg;
  assign op          = op_reg;
  assign busy        = (state_reg == S_SEND);
  assign alu_valid   = busy && (op_reg == DST_ALU);
  assign buf2_valid  = busy && (op_reg == DST_BUF2);
  assign timeout_err = timeout_err_reg;

  assign deliver[DST_ALU]  = alu_valid && alu_ready;
  assign deliver[DST_BUF2] = buf2_valid && buf2_ready;

`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0] counts [NUM_DST];

  for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_stats
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (deliver[gi]),
      .count(counts[gi])
    );
  end

  assign alu_count  = counts[DST_ALU];
  assign buf2_count = counts[DST_BUF2];
`else
  // Without statistics the delivery strobes have no consumer.
  logic unused_deliver;
  assign unused_deliver = ^deliver;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// Directed self-checking bench for demux_sched; inputs change 2 ns after each
// rising edge and outputs are sampled 1 ns later.
module tb_demux_sched;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_op;
  logic              in_ready;
  logic [DATA_W-1:0] q1;
  logic              op;
  logic              alu_valid;
  logic              alu_ready;
  logic              buf2_valid;
  logic              buf2_ready;
  logic              busy;
  logic              timeout_err;
  logic              err_clr;
`ifdef DEMUX_SCHED_STATS_EN
  logic [CNT_W-1:0]  alu_count;
  logic [CNT_W-1:0]  buf2_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_sched #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_op      (in_op),
    .in_ready   (in_ready),
    .q1         (q1),
    .op         (op),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .buf2_valid (buf2_valid),
    .buf2_ready (buf2_ready),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
`ifdef DEMUX_SCHED_STATS_EN
    ,
    .alu_count  (alu_count),
    .buf2_count (buf2_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to 2 ns past the next rising edge, where inputs may change.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_counts(input string tag, input logic [CNT_W-1:0] exp_alu, input logic [CNT_W-1:0] exp_buf2);
`ifdef DEMUX_SCHED_STATS_EN
    check({tag, "_alu_count"}, 64'(alu_count), 64'(exp_alu));
    check({tag, "_buf2_count"}, 64'(buf2_count), 64'(exp_buf2));
`else
    $display("counts %s skipped (alu=%0d buf2=%0d expected in stats build)", tag, exp_alu, exp_buf2);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_op      = 1'b0;
    alu_ready  = 1'b0;
    buf2_ready = 1'b0;
    err_clr    = 1'b0;

    // Reset state
    #12;
    check("rst_q1", 64'(q1), 64'h0);
    check("rst_op", 64'(op), 64'h0);
    check("rst_alu_valid", 64'(alu_valid), 64'h0);
    check("rst_buf2_valid", 64'(buf2_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_err", 64'(timeout_err), 64'h0);
    check_counts("rst", 16'd0, 16'd0);
    tick();
    rst_n = 1'b1;
    settle();
    check("rst_in_ready", 64'(in_ready), 64'h1);

    // Single word to ALU
    tick();
    in_valid = 1'b1; in_data = 32'h0000_00A5; in_op = 1'b0; alu_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    settle();
    $display("txn single q1=%h op=%0d alu_valid=%0d", q1, op, alu_valid);
    check("single_q1", 64'(q1), 64'h0000_00A5);
    check("single_op", 64'(op), 64'h0);
    check("single_alu_valid", 64'(alu_valid), 64'h1);
    check("single_buf2_valid", 64'(buf2_valid), 64'h0);
    check("single_busy", 64'(busy), 64'h1);
    tick();
    settle();
    check("single_idle_q1", 64'(q1), 64'h0);
    check("single_idle_busy", 64'(busy), 64'h0);
    check("single_idle_alu_valid", 64'(alu_valid), 64'h0);

    // Back-to-back stream 0x11/ALU, 0x22/BUF2, 0x33/ALU
    buf2_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h11; in_op = 1'b0;
    tick();
    in_data = 32'h22; in_op = 1'b1;
    settle();
    $display("txn stream0 q1=%h alu_valid=%0d buf2_valid=%0d", q1, alu_valid, buf2_valid);
    check("stream0_q1", 64'(q1), 64'h11);
    check("stream0_alu_valid", 64'(alu_valid), 64'h1);
    check("stream0_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_data = 32'h33; in_op = 1'b0;
    settle();
    $display("txn stream1 q1=%h alu_valid=%0d buf2_valid=%0d", q1, alu_valid, buf2_valid);
    check("stream1_q1", 64'(q1), 64'h22);
    check("stream1_op", 64'(op), 64'h1);
    check("stream1_buf2_valid", 64'(buf2_valid), 64'h1);
    check("stream1_alu_valid", 64'(alu_valid), 64'h0);
    check("stream1_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    settle();
    $display("txn stream2 q1=%h alu_valid=%0d buf2_valid=%0d", q1, alu_valid, buf2_valid);
    check("stream2_q1", 64'(q1), 64'h33);
    check("stream2_alu_valid", 64'(alu_valid), 64'h1);
    check("stream2_in_ready", 64'(in_ready), 64'h1);
    tick();
    settle();
    check("stream_idle_busy", 64'(busy), 64'h0);
    check_counts("stream", 16'd3, 16'd1);

    // Buffer2 stall for 3 cycles, toggling alu_ready must be ignored
    alu_ready = 1'b0; buf2_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_op = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_ready = (i % 2 == 0);
      settle();
      $display("txn stall%0d q1=%h op=%0d in_ready=%0d", i, q1, op, in_ready);
      check($sformatf("stall%0d_q1", i), 64'(q1), 64'hDEAD_BEEF);
      check($sformatf("stall%0d_op", i), 64'(op), 64'h1);
      check($sformatf("stall%0d_buf2_valid", i), 64'(buf2_valid), 64'h1);
      check($sformatf("stall%0d_alu_valid", i), 64'(alu_valid), 64'h0);
      check($sformatf("stall%0d_in_ready", i), 64'(in_ready), 64'h0);
      tick();
    end
    buf2_ready = 1'b1; alu_ready = 1'b0;
    settle();
    check("stall3_q1", 64'(q1), 64'hDEAD_BEEF);
    check("stall3_in_ready", 64'(in_ready), 64'h1);
    tick();
    settle();
    check("stall_idle_busy", 64'(busy), 64'h0);
    check("stall_err", 64'(timeout_err), 64'h0);
    check_counts("stall", 16'd3, 16'd2);
    buf2_ready = 1'b0;

    // Timeout abort with ALU never ready
    in_valid = 1'b1; in_data = 32'h77; in_op = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      settle();
      check($sformatf("to_cyc%0d_alu_valid", i), 64'(alu_valid), 64'h1);
      check($sformatf("to_cyc%0d_err", i), 64'(timeout_err), 64'h0);
      tick();
    end
    settle();
    $display("txn timeout busy=%0d err=%0d q1=%h", busy, timeout_err, q1);
    check("to_idle_busy", 64'(busy), 64'h0);
    check("to_idle_alu_valid", 64'(alu_valid), 64'h0);
    check("to_idle_q1", 64'(q1), 64'h0);
    check("to_err_set", 64'(timeout_err), 64'h1);
    check_counts("timeout", 16'd3, 16'd2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    check("to_err_cleared", 64'(timeout_err), 64'h0);

    // err_clr coincident with the abort: set wins
    in_valid = 1'b1; in_data = 32'h88; in_op = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      err_clr = (i == 15);
      settle();
      if (i == 15) check("to2_cyc15_in_ready", 64'(in_ready), 64'h0);
      tick();
    end
    err_clr = 1'b0;
    settle();
    $display("txn timeout_clr_race err=%0d busy=%0d", timeout_err, busy);
    check("to2_err_wins", 64'(timeout_err), 64'h1);
    check("to2_idle_busy", 64'(busy), 64'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    settle();
    check("to2_err_cleared", 64'(timeout_err), 64'h0);

    // Asynchronous reset mid-SEND
    in_valid = 1'b1; in_data = 32'h1234_5678; in_op = 1'b0;
    tick();
    in_valid = 1'b0;
    settle();
    check("arst_pre_busy", 64'(busy), 64'h1);
    check("arst_pre_q1", 64'(q1), 64'h1234_5678);
    rst_n = 1'b0;
    #1;
    $display("txn async_reset q1=%h busy=%0d", q1, busy);
    check("arst_q1", 64'(q1), 64'h0);
    check("arst_alu_valid", 64'(alu_valid), 64'h0);
    check("arst_buf2_valid", 64'(buf2_valid), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check_counts("arst", 16'd0, 16'd0);
    tick();
    rst_n = 1'b1;
    settle();
    check("arst_in_ready", 64'(in_ready), 64'h1);

`ifdef DEMUX_SCHED_STATS_EN
    // Saturation: 2^CNT_W+3 ALU deliveries
    alu_ready = 1'b1; in_op = 1'b0; in_valid = 1'b1;
    tick();
    for (int i = 1; i < (1 << CNT_W) + 3; i++) begin
      in_data = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    settle();
    $display("txn saturate alu_count=%h buf2_count=%h", alu_count, buf2_count);
    check("sat_alu_count", 64'(alu_count), 64'hFFFF);
    check("sat_buf2_count", 64'(buf2_count), 64'h0);
    check("sat_idle_busy", 64'(busy), 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
